// File: rtl/smc_feedback_pkg.sv
// Shared arithmetic for the SMC feedback path.
//   SAT_MAX / SAT_MIN : 32-bit signed saturation limits for dtheta
//   step_e            : quadrature step encoding (none, +1, -1, illegal)
//   add_mode_e        : fixed_adder operation select
//   sample_t          : registered theta / position-difference pair
//   quad_step()       : Gray transition -> step_e
package smc_feedback_pkg;

  localparam logic signed [31:0] SAT_MAX = 32'sh7FFF_FFFF;
  localparam logic signed [31:0] SAT_MIN = 32'sh8000_0000;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_FWD  = 2'd1,
    STEP_REV  = 2'd2,
    STEP_ILL  = 2'd3
  } step_e;

  typedef enum logic {
    ADD_MODE = 1'b0,
    SUB_MODE = 1'b1
  } add_mode_e;

  typedef struct packed {
    logic signed [31:0] theta;
    logic signed [31:0] diff;
  } sample_t;

  // Position of {A,B} along the forward cycle 00->01->11->10.
  function automatic logic [1:0] gray_pos(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      2'b11:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  // Distance mod 4 along the cycle: 1 fwd, 3 rev, 2 = both bits flipped.
  function automatic step_e quad_step(input logic [1:0] prev, input logic [1:0] cur);
    logic [1:0] d;
    d = gray_pos(cur) - gray_pos(prev);
    case (d)
      2'd1:    return STEP_FWD;
      2'd3:    return STEP_REV;
      2'd2:    return STEP_ILL;
      default: return STEP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/fixed_adder.sv
// Combinational W-bit modular adder/subtractor.
//   a, b : operands
//   mode : ADD_MODE -> a+b, SUB_MODE -> a-b
//   y    : result, wraps modulo 2^W
module fixed_adder
  import smc_feedback_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  add_mode_e    mode,
  output logic [W-1:0] y
);

  always_comb begin
    y = (mode == SUB_MODE) ? (a - b) : (a + b);
  end

endmodule

// File: rtl/quad_decoder.sv
// Quadrature front end: 2-flop synchronizers on A/B, a history register,
// and the Gray step / illegal-transition decode.
//   clk, rst     : clock, synchronous active-high reset
//   enc_a, enc_b : raw encoder channels (asynchronous to clk)
//   step         : decoded step for this cycle (combinational from flops)
module quad_decoder
  import smc_feedback_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  enc_a,
  input  logic  enc_b,
  output step_e step
);

  logic [1:0] sync1_q, sync1_d;
  logic [1:0] sync2_q, sync2_d;
  logic [1:0] hist_q, hist_d;
  // Counts the cycles until sync2 holds a genuine pin sample; that first
  // sample only seeds the history, so a reset-time 11 is never illegal.
  logic [1:0] arm_q, arm_d;

  always_comb begin
    sync1_d = {enc_a, enc_b};
    sync2_d = sync1_q;
    hist_d  = sync2_q;
    arm_d   = (arm_q == 2'd3) ? arm_q : arm_q + 2'd1;
    step    = (arm_q == 2'd3) ? quad_step(hist_q, sync2_q) : STEP_NONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
      hist_q  <= 2'b00;
      arm_q   <= 2'd0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      hist_q  <= hist_d;
      arm_q   <= arm_d;
    end
  end

endmodule

// File: rtl/smc_feedback.sv
// Encoder feedback for the sliding-mode controller: position count, periodic
// sampling and a shifted/saturated velocity.
//   clk, rst     : clock, synchronous active-high reset
//   enc_a, enc_b : quadrature channels (asynchronous)
//   zero         : clear position and previous-sample registers
//   theta        : sampled position (counts), updates the cycle after a tick
//   dtheta       : (pos - prev) <<< VEL_SHIFT, saturated, one cycle after theta
//   valid        : one-cycle pulse alongside each new dtheta
//   err          : sticky illegal-transition flag
module smc_feedback
  import smc_feedback_pkg::*;
#(
  parameter int SAMPLE_DIV = 1000,
  parameter int VEL_SHIFT  = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enc_a,
  input  logic               enc_b,
  input  logic               zero,
  output logic signed [31:0] theta,
  output logic signed [31:0] dtheta,
  output logic               valid,
  output logic               err
);

  localparam int         STAGES   = 1;
  localparam logic [15:0] CNT_LAST = 16'(SAMPLE_DIV - 1);

  step_e              step;
  logic signed [31:0] pos_q, pos_d, pos_step;
  logic signed [31:0] prev_q, prev_d;
  logic signed [31:0] sub_b, diff_raw;
  sample_t            smp_q, smp_d;
  logic signed [31:0] dtheta_q, dtheta_d;
  logic [15:0]        cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               tick;
  // [0] = sample registered (theta visible), [STAGES] = dtheta visible
  logic [STAGES:0]    vld_pipe_q, vld_pipe_d;
  logic signed [47:0] vel_ext, vel_shl;

  quad_decoder u_dec (
    .clk   (clk),
    .rst   (rst),
    .enc_a (enc_a),
    .enc_b (enc_b),
    .step  (step)
  );

  // Position path; zero discards any step landing in the same cycle.
  always_comb begin
    unique case (step)
      STEP_FWD: pos_step = pos_q + 32'sd1;
      STEP_REV: pos_step = pos_q - 32'sd1;
      default:  pos_step = pos_q;
    endcase
    pos_d = zero ? 32'sd0 : pos_step;
    // Zero also clears prev, so a zero on the tick yields diff = 0.
    sub_b = zero ? 32'sd0 : prev_q;
  end

  fixed_adder #(.W(32)) u_sub (
    .a    (pos_d),
    .b    (sub_b),
    .mode (SUB_MODE),
    .y    (diff_raw)
  );

  always_comb begin
    tick   = (cnt_q == CNT_LAST);
    cnt_d  = tick ? 16'd0 : cnt_q + 16'd1;
    prev_d = zero ? 32'sd0 : prev_q;
    smp_d  = smp_q;
    if (tick) begin
      smp_d.theta = pos_d;
      smp_d.diff  = diff_raw;
      prev_d      = pos_d;
    end
    vld_pipe_d = {vld_pipe_q[STAGES-1:0], tick};
    err_d      = err_q | (step == STEP_ILL);
  end

  // Velocity: widen so a 15-bit shift cannot lose the sign, then clamp.
  always_comb begin
    vel_ext  = {{16{smp_q.diff[31]}}, smp_q.diff};
    vel_shl  = vel_ext <<< VEL_SHIFT;
    dtheta_d = dtheta_q;
    if (vld_pipe_q[0]) begin
      if (&vel_shl[47:31] || !(|vel_shl[47:31])) dtheta_d = vel_shl[31:0];
      else                                       dtheta_d = vel_shl[47] ? SAT_MIN : SAT_MAX;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q      <= '0;
      prev_q     <= '0;
      smp_q      <= '0;
      dtheta_q   <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      vld_pipe_q <= '0;
    end else begin
      pos_q      <= pos_d;
      prev_q     <= prev_d;
      smp_q      <= smp_d;
      dtheta_q   <= dtheta_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      vld_pipe_q <= vld_pipe_d;
    end
  end

  assign theta  = smp_q.theta;
  assign dtheta = dtheta_q;
  assign valid  = vld_pipe_q[STAGES];
  assign err    = err_q;

endmodule

// File: doc/smc_feedback.md
SMC_FEEDBACK -- requirements
Module: smc_feedback

Interface
REQ-001 SHALL have parameter SAMPLE_DIV, default 1000: clk cycles per feedback sample; legal range 2..65535.
REQ-002 SHALL have parameter VEL_SHIFT, default 0: left shift applied to the per-sample position difference to form dtheta; legal range 0..15.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on the rising edge.
REQ-004 SHALL have port rst, input, 1: reset; one clock; reset is synchronous and active-high.
REQ-005 SHALL have port enc_a, input, 1: quadrature channel A, asynchronous to clk.
REQ-006 SHALL have port enc_b, input, 1: quadrature channel B, asynchronous to clk.
REQ-007 SHALL have port zero, input, 1: synchronous request to clear the position count.
REQ-008 SHALL have port theta, output, signed 32: sampled position, sfixed32_En0 encoder counts; feeds the sliding-mode controller theta input.
REQ-009 SHALL have port dtheta, output, signed 32: sampled velocity, counts per sample shifted by VEL_SHIFT; feeds the controller dtheta input.
REQ-010 SHALL have port valid, output, 1: one-cycle pulse marking a new theta/dtheta pair.
REQ-011 SHALL have port err, output, 1: sticky flag for an illegal quadrature transition.

Function
REQ-012 SHALL pass enc_a and enc_b each through a 2-flop synchronizer, then one history register holding the previous synchronized {A,B}.
REQ-013 SHALL decode Gray steps 00->01->11->10->00 as +1 and the reverse sequence as -1, giving 4 counts per encoder line.
REQ-014 SHALL treat a step in which both bits change as illegal: no count change, err set to 1.
REQ-015 SHALL update the internal position counter 3 clk cycles after an enc edge reaches the pins, i.e. 2 synchronizer cycles plus 1 decode/count cycle.
REQ-016 SHALL let the position counter wrap modulo 2^32 in two's complement, with no saturation.
REQ-017 SHALL, when zero=1, load 0 into the position counter and the previous-sample register in that cycle; zero takes priority over a simultaneous count step, and that step is discarded.
REQ-018 SHALL run a sample counter from 0 to SAMPLE_DIV-1; the tick fires when the counter equals SAMPLE_DIV-1, and the counter then returns to 0.
REQ-019 SHALL, on a tick cycle, register theta = position including any step in that same cycle, and register diff = position - prev_position using modular 32-bit subtraction; prev_position then takes the new position.
REQ-020 SHALL, on the cycle after a tick, register dtheta = diff <<< VEL_SHIFT, saturated to the range 0x80000000..0x7FFFFFFF, and assert valid for exactly that one cycle.
REQ-021 SHALL let theta and dtheta update only in their respective registering cycles; both hold between samples, and theta leads dtheta by 1 cycle.
REQ-022 SHALL, if zero coincides with a tick, sample theta=0 and diff=0.
REQ-023 SHALL give the sampling pipeline a latency of 2 cycles from the tick to the valid pulse, and a throughput of one sample per SAMPLE_DIV cycles.
REQ-024 SHALL keep err at 1 once set, until rst.

Reset
REQ-025 SHALL, while rst=1, reset theta=0, dtheta=0, valid=0, err=0, position=0, prev_position=0 and sample counter=0.
REQ-026 SHALL, while rst=1, load both synchronizer stages and the history register with 00.
REQ-027 SHALL let rst asserted mid-sample abort that sample, with no valid pulse; the first valid after rst release occurs SAMPLE_DIV+1 cycles after the first cycle with rst=0.
REQ-028 SHALL, after reset, not flag as illegal the first synchronized {A,B}, even if it is 11; that first value only seeds the history register.

Structure
REQ-029 SHALL place in the shared arithmetic package: the 32-bit signed saturation constants and the quadrature step encoding (+1, -1, 0, illegal).
REQ-030 SHALL use one natural sub-module, quad_decoder, containing the synchronizers, the history register and the step/illegal decode; the sample counter and velocity path stay in smc_feedback.
REQ-031 SHALL perform the modular subtraction with the existing fixed_adder in SUB mode; the shift and saturation are local logic.

Verification
REQ-032 SHALL cover forward rotation: 40 forward Gray steps spaced 10 cycles apart within one 1000-cycle window, starting from 0 -> theta=40, dtheta=40 at the next valid; err=0.
REQ-033 SHALL cover reverse rotation with shift: VEL_SHIFT=4 and 25 reverse steps -> theta=-25, dtheta=-400.
REQ-034 SHALL cover wrap: position preset near 0x7FFFFFFE by stepping, then 4 forward steps -> theta wraps to 0x80000002, dtheta=+4 with no spike.
REQ-035 SHALL cover saturation: VEL_SHIFT=15 and diff=+70000 -> dtheta=0x7FFFFFFF.
REQ-036 SHALL cover the illegal step: A and B toggled in the same cycle (00->11) -> err=1 and the count is unchanged; err stays 1 until rst.
REQ-037 SHALL cover zero priority and reset timing: zero held in the tick cycle with a pending step -> theta=0 and dtheta=0 at that valid; with rst asserted at cycle 500 of a window -> no valid that window, first valid SAMPLE_DIV+1 cycles after release.
